// File: rtl/insn_prefetch_queue_pkg.sv
// Shared definitions for the instruction prefetch queue: default widths,
// FSM state encoding and a helper for the occupancy counter width.
package insn_prefetch_queue_pkg;

  localparam int IPF_LEN_INSN = 32;
  localparam int IPF_LEN_PC   = 16;

  // At most one memory request is ever outstanding; WAIT_DISCARD marks a
  // request whose data must be thrown away because a redirect overtook it.
  typedef enum logic [1:0] {
    IPF_IDLE         = 2'd0,
    IPF_WAIT         = 2'd1,
    IPF_WAIT_DISCARD = 2'd2
  } ipf_state_t;

  // The counter must be able to hold DEPTH itself, hence one extra bit.
  function automatic int ipf_cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/insn_prefetch_queue_if.sv
// Bundle of decoder-side, execute-side and instruction-memory-side signals
// of the prefetch queue, plus read-only debug taps of the fetch FSM and PC.
//
// Handshakes:
//  - decoder: valid_o/insn_o/pc_o present the head; it is consumed at a
//    posedge where valid_o=1 and stall_i=0, otherwise it is held.
//  - memory: imem_req and imem_addr stay constant from issue until the
//    posedge where imem_ack=1; imem_rdata is only looked at in that cycle.
//  - valid_i=0 only suppresses new requests; stall_o=1 means the queue is full.
interface insn_prefetch_queue_if
  import insn_prefetch_queue_pkg::*;
#(
  parameter int LEN_INSN = IPF_LEN_INSN,
  parameter int LEN_PC   = IPF_LEN_PC
);
  logic                valid_i;
  logic                stall_o;
  logic                valid_o;
  logic                stall_i;
  logic [LEN_INSN-1:0] insn_o;
  logic [LEN_PC-1:0]   pc_o;
  logic                redirect_i;
  logic [LEN_PC-1:0]   redirect_pc_i;
  logic                imem_req;
  logic [LEN_PC-1:0]   imem_addr;
  logic                imem_ack;
  logic [LEN_INSN-1:0] imem_rdata;
  ipf_state_t          dbg_state;
  logic [LEN_PC-1:0]   dbg_pc;

  // The prefetch queue itself.
  modport master (
    input  valid_i, stall_i, redirect_i, redirect_pc_i, imem_ack, imem_rdata,
    output stall_o, valid_o, insn_o, pc_o, imem_req, imem_addr, dbg_state, dbg_pc
  );

  // Its surroundings: decoder, execute stage and instruction memory.
  modport slave (
    output valid_i, stall_i, redirect_i, redirect_pc_i, imem_ack, imem_rdata,
    input  stall_o, valid_o, insn_o, pc_o, imem_req, imem_addr, dbg_state, dbg_pc
  );
endinterface

// File: rtl/insn_prefetch_queue_fifo.sv
// ipf_fifo: DEPTH-entry circular buffer of {insn, pc} words with push, pop,
// flush and an occupancy count. The head reads as zero while empty so the
// decoder never sees stale data.
module ipf_fifo
  import insn_prefetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 48
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push,
  input  logic                        pop,
  input  logic                        flush,
  input  logic [W-1:0]                din,
  output logic [W-1:0]                head,
  output logic [ipf_cnt_w(DEPTH)-1:0] count,
  output logic                        empty,
  output logic                        full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = ipf_cnt_w(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array; no reset needed since pointers define what is live.
  always_ff @(posedge clk) begin
    if (rst && !flush && push) mem[wr_ptr] <= din;
  end

  // Head and status flags.
  always_comb begin
    empty = (count == '0);
    full  = (count == CW'(DEPTH));
    head  = empty ? '0 : mem[rd_ptr];
  end

endmodule

// File: rtl/insn_prefetch_queue.sv
// insn_prefetch_queue: instruction fetch front-end. Holds the PC, issues one
// word fetch at a time to instruction memory, buffers returned words in an
// ipf_fifo and hands them to the decoder. A redirect flushes the queue and
// discards any fetch still in flight.
// Optional feature: define IPF_BYPASS_EN to forward a returning word straight
// to the decoder outputs when the queue is empty.
module insn_prefetch_queue
  import insn_prefetch_queue_pkg::*;
#(
  parameter int          LEN_INSN = IPF_LEN_INSN,
  parameter int          LEN_PC   = IPF_LEN_PC,
  parameter int          DEPTH    = 4,
  parameter int unsigned RESET_PC = 0,
  parameter int unsigned PC_STEP  = 1
) (
  input logic                  clk,
  input logic                  rst,
  insn_prefetch_queue_if.master bus
);
  localparam int CW = ipf_cnt_w(DEPTH);
  localparam int W  = LEN_INSN + LEN_PC;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  ipf_state_t        state_q, state_d;
  logic [LEN_PC-1:0] pc_q, addr_q;
  logic              issue;
  logic              credit;
  logic              ack_live;
  logic              bypass;
  logic              push, pop;
  logic [W-1:0]      fifo_head;
  logic [CW-1:0]     fifo_count;
  logic              fifo_empty, fifo_full;

  ipf_fifo #(.DEPTH(DEPTH), .W(W)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (bus.redirect_i),
    .din   ({bus.imem_rdata, addr_q}),
    .head  (fifo_head),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  // Queue control: a redirect cancels both the pop and the push of its cycle.
  always_comb begin
    pop      = !fifo_empty && !bus.stall_i && !bus.redirect_i;
    credit   = (fifo_count < DEPTH_C) || pop;
    ack_live = (state_q == IPF_WAIT) && bus.imem_ack && !bus.redirect_i;
`ifdef IPF_BYPASS_EN
    bypass   = ack_live && fifo_empty;
`else
    bypass   = 1'b0;
`endif
    // A bypassed word taken by the decoder this cycle never enters the queue.
    push     = ack_live && !(bypass && !bus.stall_i);
  end

  // Fetch FSM state register.
  always_ff @(posedge clk) begin
    if (!rst) state_q <= IPF_IDLE;
    else      state_q <= state_d;
  end

  // Fetch FSM next state, issue decision and request strobe.
  always_comb begin
    state_d      = state_q;
    issue        = 1'b0;
    bus.imem_req = 1'b0;
    case (state_q)
      IPF_IDLE: begin
        // Issuing during a redirect would fetch from the stale PC.
        if (bus.valid_i && !bus.redirect_i && credit) begin
          issue   = 1'b1;
          state_d = IPF_WAIT;
        end
      end
      IPF_WAIT: begin
        bus.imem_req = 1'b1;
        if (bus.imem_ack)        state_d = IPF_IDLE;
        else if (bus.redirect_i) state_d = IPF_WAIT_DISCARD;
      end
      IPF_WAIT_DISCARD: begin
        bus.imem_req = 1'b1;
        if (bus.imem_ack) state_d = IPF_IDLE;
      end
      default: state_d = IPF_IDLE;
    endcase
  end

  // PC and request address registers; the address is frozen while a request is out.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q   <= LEN_PC'(RESET_PC);
      addr_q <= '0;
    end else begin
      if (bus.redirect_i) pc_q <= bus.redirect_pc_i;
      else if (ack_live)  pc_q <= pc_q + LEN_PC'(PC_STEP);
      if (issue) addr_q <= pc_q;
    end
  end

  // Decoder-facing outputs, status and debug taps.
  always_comb begin
    bus.valid_o   = !fifo_empty;
    bus.insn_o    = fifo_head[W-1 -: LEN_INSN];
    bus.pc_o      = fifo_head[LEN_PC-1:0];
    if (bypass) begin
      bus.valid_o = 1'b1;
      bus.insn_o  = bus.imem_rdata;
      bus.pc_o    = addr_q;
    end
    bus.stall_o   = fifo_full;
    bus.imem_addr = addr_q;
    bus.dbg_state = state_q;
    bus.dbg_pc    = pc_q;
  end

endmodule

// File: tb/tb_insn_prefetch_queue.sv
// Bench for insn_prefetch_queue: directed scenarios plus a randomized phase,
// all checked cycle by cycle against a queue-based reference model.
module tb_insn_prefetch_queue;
  import insn_prefetch_queue_pkg::*;

  localparam int LEN_INSN = 32;
  localparam int LEN_PC   = 16;
  localparam int DEPTH    = 4;
  localparam logic [LEN_PC-1:0] RESET_PC = 16'h0;
  localparam logic [LEN_PC-1:0] PC_STEP  = 16'h1;
`ifdef IPF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  insn_prefetch_queue_if #(.LEN_INSN(LEN_INSN), .LEN_PC(LEN_PC)) bus ();

  insn_prefetch_queue #(
    .LEN_INSN(LEN_INSN), .LEN_PC(LEN_PC), .DEPTH(DEPTH),
    .RESET_PC(0), .PC_STEP(1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- scoreboard / model state ----------------
  logic [LEN_INSN+LEN_PC-1:0] exp_q[$];   // expected queue contents {insn, pc}
  logic [LEN_PC-1:0] m_pc;
  bit                m_req;                // a request is outstanding
  bit                m_drop;               // its data must be discarded
  logic [LEN_PC-1:0] m_addr;
  int                m_age;

  int n_total = 0;
  int n_bad   = 0;
  bit chk_en  = 1'b0;
  bit auto_ack = 1'b1;
  int ack_lat  = 1;
  bit data_mode = 1'b0;                    // 0: 0x1000+addr, 1: random

  logic [63:0] seen_addr[$];               // addresses acked by memory
  logic [63:0] consumed[$];                // {insn, pc} taken by decoder
  logic [63:0] ack_valid[$];               // valid_o sampled in ack cycles
  int          n_acc;
  bit          saw_dead;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] q_at(input logic [63:0] q[$], input int i);
    if (i < q.size()) return q[i];
    return '1;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_pc = RESET_PC; m_req = 0; m_drop = 0; m_addr = '0; m_age = 0;
  endtask

  // ---------------- driver: one clock cycle ----------------
  task automatic cycle();
    bit exp_valid, byp, pop, acked;
    logic [LEN_INSN-1:0] exp_insn;
    logic [LEN_PC-1:0]   exp_pc;
    int sz;
    if (auto_ack) begin
      bus.imem_ack   = m_req && (m_age >= ack_lat);
      bus.imem_rdata = data_mode ? $urandom : 32'h1000 + 32'(m_addr);
    end
    @(negedge clk);
    sz        = exp_q.size();
    exp_valid = (sz > 0);
    exp_insn  = '0;
    exp_pc    = '0;
    byp       = 1'b0;
    if (sz > 0) {exp_insn, exp_pc} = exp_q[0];
    if (BYP && sz == 0 && m_req && !m_drop && bus.imem_ack && !bus.redirect_i) begin
      byp = 1'b1; exp_valid = 1'b1; exp_insn = bus.imem_rdata; exp_pc = m_addr;
    end
    if (chk_en) begin
      check_val("valid_o", bus.valid_o, exp_valid);
      if (exp_valid) begin
        check_val("insn_o", bus.insn_o, exp_insn);
        check_val("pc_o", bus.pc_o, exp_pc);
      end
      check_val("stall_o", bus.stall_o, sz == DEPTH);
      check_val("imem_req", bus.imem_req, m_req);
      if (m_req) check_val("imem_addr", bus.imem_addr, m_addr);
    end
    if (bus.imem_req && bus.imem_ack) begin
      seen_addr.push_back(64'(bus.imem_addr));
      ack_valid.push_back(64'(bus.valid_o));
      n_acc++;
    end
    if (bus.valid_o && !bus.stall_i && !bus.redirect_i) consumed.push_back({bus.insn_o, bus.pc_o});
    if (bus.valid_o && bus.insn_o == 32'hDEAD) saw_dead = 1'b1;
    // reference model update for this edge
    if (!rst) begin
      model_reset();
    end else begin
      pop   = (sz > 0) && !bus.stall_i && !bus.redirect_i;
      acked = m_req && bus.imem_ack;
      if (bus.redirect_i) begin
        exp_q.delete();
        m_pc = bus.redirect_pc_i;
        if (acked) begin m_req = 0; m_drop = 0; end
        else if (m_req) begin m_drop = 1; m_age++; end
      end else begin
        if (pop) void'(exp_q.pop_front());
        if (acked) begin
          if (!m_drop) begin
            if (!(byp && !bus.stall_i)) exp_q.push_back({bus.imem_rdata, m_addr});
            m_pc = m_pc + PC_STEP;
          end
          m_req = 0; m_drop = 0;
        end else if (m_req) begin
          m_age++;
        end else if (bus.valid_i && (sz < DEPTH || pop)) begin
          m_req = 1; m_addr = m_pc; m_age = 0;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.valid_i = 0; bus.stall_i = 0; bus.redirect_i = 0; bus.redirect_pc_i = '0;
    bus.imem_ack = 0; bus.imem_rdata = '0;
    auto_ack = 1; ack_lat = 1; data_mode = 0;
  endtask

  task automatic do_reset();
    drive_idle();
    rst = 0;
    cycle(); cycle();
    rst = 1;
  endtask

  task automatic drive_random();
    rst              = ($urandom_range(0, 299) != 0);
    bus.valid_i      = ($urandom_range(0, 7) != 0);
    bus.stall_i      = ($urandom_range(0, 2) == 0);
    bus.redirect_i   = ($urandom_range(0, 15) == 0);
    bus.redirect_pc_i = ($urandom_range(0, 3) == 0) ? 16'hFFFE + 16'($urandom_range(0, 1))
                                                   : 16'($urandom);
    ack_lat          = $urandom_range(0, 3);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    drive_idle();
    model_reset();
    @(posedge clk); #1;
    do_reset();
    chk_en = 1;

    // 1: streaming fetch, ack one cycle after each request
    check_val("rst_valid_o", bus.valid_o, 1'b0);
    check_val("rst_imem_req", bus.imem_req, 1'b0);
    check_val("rst_stall_o", bus.stall_o, 1'b0);
    check_val("rst_insn_o", bus.insn_o, 32'h0);
    check_val("rst_pc_o", bus.pc_o, 16'h0);
    check_val("rst_imem_addr", bus.imem_addr, 16'h0);
    check_val("rst_state", bus.dbg_state, IPF_IDLE);
    check_val("rst_pc", bus.dbg_pc, RESET_PC);
    seen_addr.delete(); consumed.delete(); ack_valid.delete();
    bus.valid_i = 1;
    repeat (20) cycle();
    for (int i = 0; i < 4; i++) check_val($sformatf("t1_addr%0d", i), q_at(seen_addr, i), 64'(i));
    check_val("t1_head0", q_at(consumed, 0), {16'h0, 32'h1000, 16'h0});
    check_val("t1_head1", q_at(consumed, 1), {16'h0, 32'h1001, 16'h1});
    check_val("t1_ack_valid", q_at(ack_valid, 0), 64'(BYP));

    // 2: decoder stalled, queue fills and fetching stops
    do_reset();
    bus.valid_i = 1; bus.stall_i = 1; n_acc = 0;
    repeat (30) cycle();
    check_val("t2_acks", n_acc, 4);
    check_val("t2_stall_o", bus.stall_o, 1'b1);
    check_val("t2_imem_req", bus.imem_req, 1'b0);
    bus.stall_i = 0; consumed.delete(); seen_addr.delete();
    repeat (20) cycle();
    for (int i = 0; i < 4; i++) check_val($sformatf("t2_drain%0d", i), q_at(consumed, i) & 64'hFFFF, 64'(i));
    check_val("t2_resume", q_at(seen_addr, 0), 64'h4);

    // 3: redirect while waiting on addr 5, late ack with 0xDEAD is dropped
    do_reset();
    bus.valid_i = 1;
    for (int i = 0; i < 40 && !(m_req && m_addr == 16'h5); i++) cycle();
    check_val("t3_reach", bus.imem_addr, 16'h5);
    auto_ack = 0; bus.imem_ack = 0;
    bus.redirect_i = 1; bus.redirect_pc_i = 16'h40;
    cycle();
    bus.redirect_i = 0;
    check_val("t3_state", bus.dbg_state, IPF_WAIT_DISCARD);
    check_val("t3_valid_o", bus.valid_o, 1'b0);
    check_val("t3_req_held", bus.imem_req, 1'b1);
    check_val("t3_addr_held", bus.imem_addr, 16'h5);
    cycle();
    bus.imem_ack = 1; bus.imem_rdata = 32'hDEAD;
    saw_dead = 0; seen_addr.delete();
    cycle();
    bus.imem_ack = 0; auto_ack = 1;
    repeat (10) cycle();
    check_val("t3_no_dead", saw_dead, 1'b0);
    check_val("t3_next_addr", q_at(seen_addr, 1), 64'h40);

    // 4: redirect coinciding with an ack and a pop
    do_reset();
    bus.valid_i = 1; bus.stall_i = 1;
    repeat (8) cycle();
    for (int i = 0; i < 20 && !(m_req && m_age >= ack_lat && exp_q.size() > 0); i++) cycle();
    check_val("t4_setup_valid", bus.valid_o, 1'b1);
    bus.stall_i = 0; bus.redirect_i = 1; bus.redirect_pc_i = 16'h80;
    cycle();
    bus.redirect_i = 0;
    check_val("t4_valid_o", bus.valid_o, 1'b0);
    check_val("t4_stall_o", bus.stall_o, 1'b0);
    check_val("t4_pc", bus.dbg_pc, 16'h80);
    seen_addr.delete();
    repeat (8) cycle();
    check_val("t4_next_addr", q_at(seen_addr, 0), 64'h80);

    // 5: PC wraps from 0xFFFF to 0x0000
    do_reset();
    bus.redirect_i = 1; bus.redirect_pc_i = 16'hFFFF;
    cycle();
    bus.redirect_i = 0; bus.valid_i = 1;
    seen_addr.delete();
    repeat (10) cycle();
    check_val("t5_addr0", q_at(seen_addr, 0), 64'hFFFF);
    check_val("t5_addr1", q_at(seen_addr, 1), 64'h0);

    // 6: reset while a request is outstanding; a stray ack afterwards is ignored
    do_reset();
    bus.valid_i = 1; ack_lat = 5;
    for (int i = 0; i < 10 && !m_req; i++) cycle();
    check_val("t6_req_up", bus.imem_req, 1'b1);
    rst = 0;
    cycle();
    rst = 1; bus.valid_i = 0;
    check_val("t6_valid_o", bus.valid_o, 1'b0);
    check_val("t6_imem_req", bus.imem_req, 1'b0);
    check_val("t6_imem_addr", bus.imem_addr, 16'h0);
    check_val("t6_insn_o", bus.insn_o, 32'h0);
    check_val("t6_pc_o", bus.pc_o, 16'h0);
    check_val("t6_pc", bus.dbg_pc, RESET_PC);
    auto_ack = 0; bus.imem_ack = 1; bus.imem_rdata = 32'hBAD;
    cycle();
    bus.imem_ack = 0; auto_ack = 1;
    cycle();
    check_val("t6_stray_ack", bus.valid_o, 1'b0);

    // randomized traffic
    do_reset();
    data_mode = 1;
    for (int i = 0; i < 3000; i++) begin
      drive_random();
      cycle();
    end
    rst = 1;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
